// File: rtl/gp_seq_pkg.sv
// Shared types for the general-purpose register-file sequencer:
// command opcodes, sequencer states and the register select width.
package gp_seq_pkg;

    localparam int REG_SEL_W = 3;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_LDI = 2'b01,
        OP_SWP = 2'b10,
        OP_RD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ_A  = 3'd1,
        ST_READ_B  = 3'd2,
        ST_WRITE_A = 3'd3,
        ST_WRITE_B = 3'd4
    } state_e;

endpackage

// File: rtl/gp_reg_sequencer.sv
// Register-file bus initiator: turns MOV/LDI/SWP/RD commands into timed
// read (out_en) and write (write_en) phases on the register-file bus.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for a command; done/rd_valid pulse here after a command
// ST_READ_A  | out_en, sel=src, rdata captured into tmp_a (and rd_data for RD)
// ST_READ_B  | out_en, sel=dst, rdata captured into tmp_b (SWP only)
// ST_WRITE_A | write_en, sel=dst, wdata=imm (LDI) or tmp_a
// ST_WRITE_B | write_en, sel=src, wdata=tmp_b (SWP only)
module gp_reg_sequencer
    import gp_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [REG_SEL_W-1:0] cmd_src,
    input  logic [REG_SEL_W-1:0] cmd_dst,
    input  logic [N-1:0]         cmd_imm,
    output logic                 rf_write_en,
    output logic                 rf_out_en,
    output logic [REG_SEL_W-1:0] rf_sel,
    output logic [N-1:0]         rf_wdata,
    input  logic [N-1:0]         rf_rdata,
    output logic                 rd_valid,
    output logic [N-1:0]         rd_data,
    output logic                 busy,
    output logic                 done
);

    if (NREGS != (1 << REG_SEL_W)) begin : g_nregs_check
        $error("NREGS must match the fixed register select width");
    end

    state_e                 state_q, state_d;
    op_e                    op_q;
    logic [REG_SEL_W-1:0]   src_q, dst_q;
    logic [N-1:0]           imm_q, tmp_a_q, tmp_b_q, rd_data_q;
    logic                   done_q, rd_valid_q;
    logic                   accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_e'(cmd_op) == OP_LDI) ? ST_WRITE_A : ST_READ_A;
                end
            end
            ST_READ_A: begin
                unique case (op_q)
                    OP_MOV:  state_d = ST_WRITE_A;
                    OP_SWP:  state_d = ST_READ_B;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_READ_B:  state_d = ST_WRITE_A;
            ST_WRITE_A: state_d = (op_q == OP_SWP) ? ST_WRITE_B : ST_IDLE;
            ST_WRITE_B: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus enables are gated by rst_n so a reset asserted mid-phase
    // suppresses that phase's write before the edge that commits it.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        rf_write_en = 1'b0;
        rf_out_en   = 1'b0;
        rf_sel      = '0;
        rf_wdata    = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_READ_A: begin
                rf_out_en = 1'b1;
                rf_sel    = src_q;
            end
            ST_READ_B: begin
                rf_out_en = 1'b1;
                rf_sel    = dst_q;
            end
            ST_WRITE_A: begin
                rf_write_en = 1'b1;
                rf_sel      = dst_q;
                rf_wdata    = (op_q == OP_LDI) ? imm_q : tmp_a_q;
            end
            ST_WRITE_B: begin
                rf_write_en = 1'b1;
                rf_sel      = src_q;
                rf_wdata    = tmp_b_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
        if (!rst_n) begin
            cmd_ready   = 1'b0;
            rf_write_en = 1'b0;
            rf_out_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_MOV;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            tmp_a_q    <= '0;
            tmp_b_q    <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                imm_q <= cmd_imm;
            end
            if (state_q == ST_READ_A) begin
                tmp_a_q <= rf_rdata;
                if (op_q == OP_RD) begin
                    rd_data_q <= rf_rdata;
                end
            end
            if (state_q == ST_READ_B) begin
                tmp_b_q <= rf_rdata;
            end
            done_q     <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            rd_valid_q <= (state_q == ST_READ_A) && (op_q == OP_RD);
        end
    end

    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_gp_reg_sequencer.sv
// Bench for gp_reg_sequencer: behavioural register file plus a scoreboard
// of expected bus phases and RD results checked as the DUT produces them.
module tb_gp_reg_sequencer;
    import gp_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src, cmd_dst;
    logic [7:0] cmd_imm;
    logic       rf_write_en, rf_out_en;
    logic [2:0] rf_sel;
    logic [7:0] rf_wdata, rf_rdata;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       we;
        logic [2:0] sel;
        logic [7:0] wdata;
    } phase_t;

    phase_t     exp_ph[$];
    logic [7:0] exp_rd[$];
    phase_t     ph;
    logic [7:0] rf [8];

    gp_reg_sequencer #(.N(8), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rf_write_en(rf_write_en), .rf_out_en(rf_out_en), .rf_sel(rf_sel),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_write_en) rf[rf_sel] <= rf_wdata;
    end
    assign rf_rdata = rf_out_en ? rf[rf_sel] : 8'h00;

    // scoreboard: every bus phase and rd_valid pulse pops one expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            if (rf_write_en || rf_out_en) begin
                total++; bad++;
                $display("FAIL bus_in_reset: we=%0b oe=%0b required 0/0", rf_write_en, rf_out_en);
            end
        end else if (rf_write_en || rf_out_en) begin
            total++;
            if (exp_ph.size() == 0) begin
                bad++;
                $display("FAIL unexpected_phase: we=%0b oe=%0b sel=%0d", rf_write_en, rf_out_en, rf_sel);
            end else begin
                ph = exp_ph.pop_front();
                if (rf_write_en !== ph.we || rf_out_en !== !ph.we || rf_sel !== ph.sel ||
                    (ph.we && rf_wdata !== ph.wdata)) begin
                    bad++;
                    $display("FAIL bus_phase: got we=%0b oe=%0b sel=%0d wdata=%h required we=%0b sel=%0d wdata=%h",
                             rf_write_en, rf_out_en, rf_sel, rf_wdata, ph.we, ph.sel, ph.wdata);
                end
            end
        end
        if (rst_n && rd_valid) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid: rd_data=%h", rd_data);
            end else begin
                if (rd_data !== exp_rd[0] || done !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_result: got rd_data=%h done=%0b required %h done=1", rd_data, done, exp_rd[0]);
                end
                void'(exp_rd.pop_front());
            end
        end
    end

    function automatic void push_exp(op_e op, logic [2:0] src, logic [2:0] dst, logic [7:0] imm);
        case (op)
            OP_MOV: begin
                exp_ph.push_back('{1'b0, src, 8'h00});
                exp_ph.push_back('{1'b1, dst, rf[src]});
            end
            OP_LDI: exp_ph.push_back('{1'b1, dst, imm});
            OP_SWP: begin
                exp_ph.push_back('{1'b0, src, 8'h00});
                exp_ph.push_back('{1'b0, dst, 8'h00});
                exp_ph.push_back('{1'b1, dst, rf[src]});
                exp_ph.push_back('{1'b1, src, rf[dst]});
            end
            default: begin
                exp_ph.push_back('{1'b0, src, 8'h00});
                exp_rd.push_back(rf[src]);
            end
        endcase
    endfunction

    // returns one time unit after the accepting edge, with cmd_* scrambled
    task automatic issue(input op_e op, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm);
        int n = 0;
        push_exp(op, src, dst, imm);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 20) begin
                total++; bad++;
                $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_src = 3'($urandom); cmd_dst = 3'($urandom); cmd_imm = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= 20) begin
                total++; bad++;
                $display("FAIL done_timeout: no done within %0d cycles", cyc);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_imm = 8'h00;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b0) begin
                bad++; $display("FAIL ready_in_reset: got %0b required 0", cmd_ready);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf_write_en !== 1'b0 || rf_out_en !== 1'b0 ||
            rf_sel !== 3'd0 || rf_wdata !== 8'h00 || done !== 1'b0 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: ready=%0b busy=%0b we=%0b oe=%0b sel=%0d wdata=%h done=%0b rd_data=%h required 1,0,0,0,0,00,0,00",
                     cmd_ready, busy, rf_write_en, rf_out_en, rf_sel, rf_wdata, done, rd_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldi_rd();
        int cyc;
        issue(OP_LDI, 3'd0, 3'd3, 8'hA5);
        wait_done(cyc);
        total++;
        if (cyc != 2) begin bad++; $display("FAIL ldi_latency: got %0d required 2", cyc); end
        issue(OP_RD, 3'd3, 3'd6, 8'h00);
        wait_done(cyc);
        total++;
        if (cyc != 2) begin bad++; $display("FAIL rd_latency: got %0d required 2", cyc); end
        total++;
        if (rd_data !== 8'hA5) begin bad++; $display("FAIL rd_hold: got %h required a5", rd_data); end
    endtask

    task automatic test_mov();
        int cyc;
        issue(OP_LDI, 3'd0, 3'd2, 8'h3C);
        wait_done(cyc);
        issue(OP_MOV, 3'd2, 3'd5, 8'h00);
        wait_done(cyc);
        total++;
        if (cyc != 3) begin bad++; $display("FAIL mov_latency: got %0d required 3", cyc); end
        total++;
        if (rd_data !== 8'hA5) begin bad++; $display("FAIL rd_held_over_mov: got %h required a5", rd_data); end
        issue(OP_RD, 3'd5, 3'd0, 8'h00);
        wait_done(cyc);
        total++;
        if (rd_data !== 8'h3C || rf[2] !== 8'h3C) begin
            bad++; $display("FAIL mov_result: got r5=%h r2=%h required 3c 3c", rd_data, rf[2]);
        end
        // same source and destination: contents must survive
        issue(OP_MOV, 3'd5, 3'd5, 8'h00);
        wait_done(cyc);
        total++;
        if (rf[5] !== 8'h3C) begin bad++; $display("FAIL mov_self: got %h required 3c", rf[5]); end
    endtask

    task automatic test_swp();
        int cyc;
        issue(OP_LDI, 3'd0, 3'd0, 8'h11);
        wait_done(cyc);
        issue(OP_LDI, 3'd0, 3'd1, 8'h22);
        wait_done(cyc);
        issue(OP_SWP, 3'd0, 3'd1, 8'h00);
        wait_done(cyc);
        total++;
        if (cyc != 5) begin bad++; $display("FAIL swp_latency: got %0d required 5", cyc); end
        total++;
        if (rf[0] !== 8'h22 || rf[1] !== 8'h11) begin
            bad++; $display("FAIL swp_result: got r0=%h r1=%h required 22 11", rf[0], rf[1]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n = 0;
        push_exp(OP_LDI, 3'd0, 3'd4, 8'h01);
        push_exp(OP_LDI, 3'd0, 3'd4, 8'h02);
        cmd_valid = 1'b1; cmd_op = OP_LDI; cmd_src = 3'd0; cmd_dst = 3'd4; cmd_imm = 8'h01;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 20);
        @(posedge clk); #1;
        cmd_imm = 8'h02;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_busy: ready=%0b busy=%0b required 0 1", cmd_ready, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_done_accept: done=%0b ready=%0b required 1 1", done, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 2 || rf[4] !== 8'h02) begin
            bad++; $display("FAIL b2b_result: cyc=%0d r4=%h required 2 02", cyc, rf[4]);
        end
    endtask

    task automatic test_handshake();
        // r3=a5, r5=3c; SWP while cmd_* toggles underneath
        issue(OP_SWP, 3'd3, 3'd5, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            cmd_valid = (k <= 3) ? 1'($urandom) : 1'b0;
            cmd_op = 2'($urandom); cmd_src = 3'($urandom); cmd_dst = 3'($urandom); cmd_imm = 8'($urandom);
            @(negedge clk);
            total++;
            if (k <= 4 && (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0)) begin
                bad++; $display("FAIL hs_busy%0d: ready=%0b busy=%0b done=%0b required 0 1 0", k, cmd_ready, busy, done);
            end else if (k == 5 && done !== 1'b1) begin
                bad++; $display("FAIL hs_done: got %0b required 1", done);
            end
            @(posedge clk); #1;
        end
        total++;
        if (rf[3] !== 8'h3C || rf[5] !== 8'hA5 || exp_ph.size() != 0) begin
            bad++; $display("FAIL hs_result: r3=%h r5=%h left=%0d required 3c a5 0", rf[3], rf[5], exp_ph.size());
        end
    endtask

    task automatic test_reset_mid_swp();
        int cyc;
        issue(OP_LDI, 3'd0, 3'd6, 8'hAA);
        wait_done(cyc);
        issue(OP_LDI, 3'd0, 3'd7, 8'h55);
        wait_done(cyc);
        issue(OP_SWP, 3'd6, 3'd7, 8'h00);
        void'(exp_ph.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b required 0", done); end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || rd_data !== 8'h00) begin
                bad++; $display("FAIL abort_idle: busy=%0b ready=%0b done=%0b rd_data=%h required 0 1 0 00",
                                busy, cmd_ready, done, rd_data);
            end
            @(posedge clk); #1;
        end
        total++;
        if (rf[6] !== 8'hAA || rf[7] !== 8'hAA || exp_ph.size() != 0) begin
            bad++; $display("FAIL abort_regs: r6=%h r7=%h left=%0d required aa aa 0", rf[6], rf[7], exp_ph.size());
        end
    endtask

    initial begin
        test_reset();
        test_ldi_rd();
        test_mov();
        test_swp();
        test_back_to_back();
        test_handshake();
        test_reset_mid_swp();
        total++;
        if (exp_ph.size() != 0 || exp_rd.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: phases=%0d rds=%0d required 0 0", exp_ph.size(), exp_rd.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gp_reg_sequencer.md
Name: gp_reg_sequencer

Overview:
Bus initiator for the 8-entry general-purpose register file. It accepts one transfer command at a time over a valid/ready handshake and turns it into a timed sequence of register-file read and write phases. It drives the write enable, output enable, select and write data, and samples the register file's read data. Supported commands: move, load-immediate, swap and read-out. It sits between the control unit and the register file, so control logic never sequences bus phases itself.

Parameters:
N, 8, data width of the register file and bus
NREGS, 8, number of addressable registers (select width fixed at 3 bits)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 MOV, 01 LDI, 10 SWP, 11 RD
cmd_src  input  3  source register index
cmd_dst  input  3  destination register index
cmd_imm  input  N  immediate for LDI
rf_write_en  output  1  register-file write enable
rf_out_en  output  1  register-file output enable (read phase)
rf_sel  output  3  register-file select
rf_wdata  output  N  register-file write data
rf_rdata  input  N  register-file read data (valid while rf_out_en=1)
rd_valid  output  1  one-cycle pulse, rd_data valid (RD only)
rd_data  output  N  value read by last RD, held until next RD
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final phase of any command

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. Command latches, tmp_a, tmp_b and rd_data are cleared to 0. done and rd_valid are 0.
- During reset cycles cmd_ready=0. It becomes 1 in the first cycle after rst_n returns high.
- States: IDLE, READ_A, READ_B, WRITE_A, WRITE_B.
- Bus outputs are decoded from the state and latched fields only (Moore outputs); they never depend on cmd_* directly.
- IDLE: cmd_ready=1, busy=0, rf_write_en=0, rf_out_en=0, rf_sel=0, rf_wdata=0.
- Accept: when cmd_valid and cmd_ready are both high at an edge, latch op/src/dst/imm. After accept, changes on cmd_* are ignored until the next accept.
- Per-op transitions:
  - MOV: IDLE -> READ_A -> WRITE_A -> IDLE.
  - LDI: IDLE -> WRITE_A -> IDLE.
  - SWP: IDLE -> READ_A -> READ_B -> WRITE_A -> WRITE_B -> IDLE.
  - RD: IDLE -> READ_A -> IDLE.
- READ_A: rf_out_en=1, rf_sel=src. Sample rf_rdata into tmp_a at the end of the cycle.
- READ_B: rf_out_en=1, rf_sel=dst. Sample rf_rdata into tmp_b.
- WRITE_A: rf_write_en=1, rf_sel=dst. rf_wdata=imm for LDI, otherwise tmp_a.
- WRITE_B: rf_write_en=1, rf_sel=src, rf_wdata=tmp_b.
- rf_write_en and rf_out_en are never high in the same cycle.
- Bus-phase counts: MOV 2, LDI 1, SWP 4, RD 1.
- done pulses for one cycle in the first IDLE cycle after the last phase. A new command may be accepted in that same cycle, giving back-to-back throughput with no gap cycle.
- RD: in the cycle after READ_A, rd_data is loaded from rf_rdata and rd_valid pulses together with done. rd_data holds until the next RD.
- src == dst:
  - MOV and SWP still execute every phase; net register contents are unchanged.
  - RD and LDI ignore the unused field.
- Reset mid-command aborts immediately; no further write phase is issued. A SWP aborted after WRITE_A leaves dst updated and src unchanged, and the reset is the only way to abort.
- Widths: all data paths are N bits, with no arithmetic and no truncation.

Decomposition:
- Shared package gp_seq_pkg:
  - op enum (OP_MOV, OP_LDI, OP_SWP, OP_RD) with 2-bit encodings as above.
  - state enum (ST_IDLE, ST_READ_A, ST_READ_B, ST_WRITE_A, ST_WRITE_B).
  - constant REG_SEL_W = 3.
- No sub-module. Single file: state register, next-state logic, output decode, data latches.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release. Expect cmd_ready=1, busy=0, all rf_* outputs 0, done=0, rd_data=0.
- LDI then RD: LDI dst=3 imm=8'hA5 (1 write cycle with rf_sel=3, rf_wdata=A5, done next cycle), then RD src=3. Expect rd_valid pulse with rd_data=8'hA5, 2 cycles after accept.
- MOV: preload r2=8'h3C. MOV src=2 dst=5 gives READ_A with sel=2, then WRITE_A with sel=5 and wdata=3C. A subsequent RD of r5 returns 8'h3C and r2 is unchanged.
- SWP: r0=8'h11, r1=8'h22. SWP src=0 dst=1 takes 4 phases (out_en,out_en,write,write) with sel 0,1,1,0. Afterwards r0=8'h22, r1=8'h11, and done pulses 5 cycles after accept.
- Back-to-back and handshake:
  - Hold cmd_valid high with LDI r4=8'h01 then LDI r4=8'h02. The second is accepted in the done cycle of the first, and r4 ends at 8'h02.
  - cmd_ready is 0 throughout busy, and cmd_* toggling mid-command has no effect.
- Reset mid-SWP: r6=8'hAA, r7=8'h55. Assert rst_n=0 during WRITE_B. Expect r7=8'hAA, r6=8'hAA, no further rf_write_en, state IDLE after release, and no done pulse.
